// File: rtl/pipe_latch_chain.sv
// pipe_latch_chain
//   A chain of STAGES registered slots, each W bits wide with its own valid
//   bit, placed between a producer and a consumer pipeline stage. Words move
//   toward the output one slot per clock. A valid slot advances whenever its
//   successor is empty or emptying on the same edge, so bubbles collapse
//   while the consumer is stalled. Each slot can be flushed on its own, a
//   global stall freezes all movement, and the number of valid slots is
//   reported.
//
// Parameters
//   W       payload width in bits (>= 1)
//   STAGES  number of slots (>= 1); slot 0 is the input side and slot
//           STAGES-1 drives the outputs
//   CW      occupancy width; 2**CW must be greater than STAGES
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset; clears all valid and data
//   in_valid    producer presents in_data
//   in_ready    chain accepts in_data this cycle
//   in_data     payload from producer
//   out_valid   last slot holds valid data and no stall is active
//   out_ready   consumer accepts out_data this cycle
//   out_data    payload of the last slot
//   stall       global freeze; no slot moves and no transfer happens
//   flush       bit i clears the valid bit of slot i at this edge
//   slot_valid  valid bit of each slot
//   occupancy   number of valid slots
module pipe_latch_chain #(
  parameter int W      = 32,
  parameter int STAGES = 4,
  parameter int CW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  input  logic              stall,
  input  logic [STAGES-1:0] flush,
  output logic [STAGES-1:0] slot_valid,
  output logic [CW-1:0]     occupancy
);

  logic [STAGES-1:0] v;
  logic [W-1:0]      d [STAGES];
  logic [STAGES-1:0] mv;
  logic              accept;

  function automatic logic [CW-1:0] popcount(input logic [STAGES-1:0] x);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < STAGES; i++) begin
      c = c + CW'(x[i]);
    end
    return c;
  endfunction

  // Movement resolves from the output end backward: a slot may advance only
  // when its successor is empty or is itself advancing on this edge.
  always_comb begin
    mv = '0;
    if (!stall) begin
      mv[STAGES-1] = v[STAGES-1] & out_ready;
      for (int i = STAGES - 2; i >= 0; i--) begin
        mv[i] = v[i] & (!v[i+1] | mv[i+1]);
      end
    end
  end

  assign in_ready   = !stall & (!v[0] | mv[0]);
  assign accept     = in_valid & in_ready;
  assign out_valid  = v[STAGES-1] & !stall;
  assign out_data   = d[STAGES-1];
  assign slot_valid = v;
  assign occupancy  = popcount(v);

  // Slot registers. The flush is applied last so that it kills whatever the
  // slot holds after this edge, including a word that just moved in. A word
  // moving out of a flushed slot still reaches its destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d[i] <= '0;
      end
    end else begin
      if (accept) begin
        d[0] <= in_data;
        v[0] <= 1'b1;
      end else if (mv[0]) begin
        v[0] <= 1'b0;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (mv[i-1]) begin
          d[i] <= d[i-1];
          v[i] <= 1'b1;
        end else if (mv[i]) begin
          v[i] <= 1'b0;
        end
      end
      for (int i = 0; i < STAGES; i++) begin
        if (flush[i]) begin
          v[i] <= 1'b0;
        end
      end
    end
  end

endmodule
